key_mode_ctrl: RTL and testbench



---
 rtl/key_mode_pkg.sv | 23 ++
 rtl/key_debounce.sv | 63 ++++++
 rtl/key_mode_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_key_mode_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/key_mode_pkg.sv
// key_mode_pkg
//   Shared types and constants for the front-panel key/mode controller.
//   - rpt_state_e : auto-repeat FSM state
//   - KEY_*       : fixed key function indices
//   - cnt_width() : counter width able to hold 0..n-1 (never less than 1)
package key_mode_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } rpt_state_e;

    localparam int KEY_NEXT   = 0;
    localparam int KEY_PREV   = 1;
    localparam int KEY_FREEZE = 2;
    localparam int KEY_CLEAR  = 3;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce
//   One push-button: 2-flop synchroniser followed by a stability counter.
//   The accepted level only changes after the synchronised input has
//   differed from it for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   iCLK      in   system clock
//   iRST      in   synchronous reset, active high
//   key_i     in   raw button level, asynchronous to iCLK
//   stable_o  out  debounced level
//   rise_o    out  one-cycle pulse on each debounced rising edge (registered)
module key_debounce
    import key_mode_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic key_i,
    output logic stable_o,
    output logic rise_o
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_dly_q;
    logic             rise_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            rise_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;

            // Any return to the accepted level restarts the qualification window.
            if (sync2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_q <= sync2_q;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end

            stable_dly_q <= stable_q;
            rise_q       <= stable_q & ~stable_dly_q;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = rise_q;

endmodule

// File: rtl/key_mode_ctrl.sv
// key_mode_ctrl
//   Front-panel controller for the image pipeline. Debounces the keys,
//   arbitrates press events, stages mode/freeze changes (with hold-to-repeat
//   on next/prev) and commits the staged values only at frame start.
//   Keys 0..3 have fixed functions; NUM_KEYS must be at least 4.
// Ports:
//   iCLK         in   system clock
//   iRST         in   synchronous reset, active high
//   iKey         in   raw buttons, active high, asynchronous
//   iFrameStart  in   one-cycle frame start pulse (commit point)
//   oNewPress    out  one-cycle pulse per debounced rising edge
//   oMode        out  committed mode
//   oFreeze      out  committed freeze flag
//   oPending     out  staged values differ from committed values
//
// Auto-repeat FSM:
//   state  | meaning
//   IDLE   | no direction key being held
//   HOLD   | direction key held, waiting HOLD_CYCLES before repeating
//   REPEAT | stepping once every REPEAT_CYCLES while the key stays held
module key_mode_ctrl
    import key_mode_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned MODE_W          = 3,
    parameter int unsigned NUM_MODES       = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned HOLD_CYCLES     = 25000000,
    parameter int unsigned REPEAT_CYCLES   = 10000000
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic [NUM_KEYS-1:0] iKey,
    input  logic                iFrameStart,
    output logic [NUM_KEYS-1:0] oNewPress,
    output logic [MODE_W-1:0]   oMode,
    output logic                oFreeze,
    output logic                oPending
);

    localparam int unsigned TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned CNT_W   = cnt_width(TMR_MAX);
    localparam logic [CNT_W-1:0]  HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [MODE_W-1:0] MODE_LAST   = MODE_W'(NUM_MODES - 1);

    logic [NUM_KEYS-1:0] stable_w;
    logic [NUM_KEYS-1:0] press_w;

    for (genvar k = 0; k < int'(NUM_KEYS); k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .iCLK     (iCLK),
            .iRST     (iRST),
            .key_i    (iKey[k]),
            .stable_o (stable_w[k]),
            .rise_o   (press_w[k])
        );
    end

    // Only the direction keys' levels matter to the FSM.
    logic unused_stable;
    assign unused_stable = ^stable_w[NUM_KEYS-1:KEY_FREEZE];

    assign oNewPress = press_w;

    // Fixed priority: clear > freeze > prev > next.
    logic win_clr, win_frz, win_prev, win_next;
    assign win_clr  = press_w[KEY_CLEAR];
    assign win_frz  = press_w[KEY_FREEZE] & ~press_w[KEY_CLEAR];
    assign win_prev = press_w[KEY_PREV] & ~press_w[KEY_FREEZE] & ~press_w[KEY_CLEAR];
    assign win_next = press_w[KEY_NEXT] & ~press_w[KEY_PREV] & ~press_w[KEY_FREEZE]
                    & ~press_w[KEY_CLEAR];

    rpt_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dir_q, dir_d;          // 1 = prev, 0 = next
    logic [MODE_W-1:0] mode_stg_q, mode_stg_d;
    logic              frz_stg_q, frz_stg_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic              frz_q, frz_d;
    logic              pend_q, pend_d;

    logic held_w;
    logic rpt_step;
    logic step_up;
    logic step_dn;

    assign held_w = dir_q ? stable_w[KEY_PREV] : stable_w[KEY_NEXT];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        rpt_step = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_next | win_prev) begin
                    state_d = HOLD;
                    dir_d   = win_prev;
                    cnt_d   = '0;
                end
            end
            HOLD, REPEAT: begin
                if (win_clr | win_frz) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (win_next | win_prev) begin
                    // A fresh direction press restarts the hold delay.
                    state_d = HOLD;
                    dir_d   = win_prev;
                    cnt_d   = '0;
                end else if (!held_w) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if ((state_q == HOLD) && (cnt_q == HOLD_LAST)) begin
                    state_d  = REPEAT;
                    cnt_d    = '0;
                    rpt_step = 1'b1;
                end else if ((state_q == REPEAT) && (cnt_q == REPEAT_LAST)) begin
                    cnt_d    = '0;
                    rpt_step = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Press steps and repeat steps never coincide: a press preempts the timer.
        step_up = win_next | (rpt_step & ~dir_q);
        step_dn = win_prev | (rpt_step & dir_q);

        mode_stg_d = mode_stg_q;
        frz_stg_d  = frz_stg_q;
        if (win_clr) begin
            mode_stg_d = '0;
            frz_stg_d  = 1'b0;
        end else if (win_frz) begin
            frz_stg_d = ~frz_stg_q;
        end else if (step_up) begin
            mode_stg_d = (mode_stg_q == MODE_LAST) ? '0 : mode_stg_q + 1'b1;
        end else if (step_dn) begin
            mode_stg_d = (mode_stg_q == '0) ? MODE_LAST : mode_stg_q - 1'b1;
        end

        // Commit takes the staged value from before this cycle's action.
        mode_d = iFrameStart ? mode_stg_q : mode_q;
        frz_d  = iFrameStart ? frz_stg_q  : frz_q;
        pend_d = (mode_stg_q != mode_q) | (frz_stg_q != frz_q);
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dir_q      <= 1'b0;
            mode_stg_q <= '0;
            frz_stg_q  <= 1'b0;
            mode_q     <= '0;
            frz_q      <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            mode_stg_q <= mode_stg_d;
            frz_stg_q  <= frz_stg_d;
            mode_q     <= mode_d;
            frz_q      <= frz_d;
            pend_q     <= pend_d;
        end
    end

    assign oMode    = mode_q;
    assign oFreeze  = frz_q;
    assign oPending = pend_q;

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Bench for key_mode_ctrl with short debounce/hold/repeat timings.
module tb_key_mode_ctrl;

    localparam int NK = 4;
    localparam int MW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] key = '0;
    logic          fs  = 1'b0;
    logic [NK-1:0] new_press;
    logic [MW-1:0] mode;
    logic          freeze;
    logic          pending;

    always #5 clk = ~clk;

    key_mode_ctrl #(
        .NUM_KEYS        (NK),
        .MODE_W          (MW),
        .NUM_MODES       (8),
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (16),
        .REPEAT_CYCLES   (4)
    ) dut (
        .iCLK        (clk),
        .iRST        (rst),
        .iKey        (key),
        .iFrameStart (fs),
        .oNewPress   (new_press),
        .oMode       (mode),
        .oFreeze     (freeze),
        .oPending    (pending)
    );

    typedef struct {
        logic [3:0] keys;
        logic [3:0] exp_press;
        int         exp_mode;
        logic       exp_frz;
    } vec_t;

    vec_t vecs [13];

    int total = 0;
    int bad   = 0;
    int cur_mode;
    logic cur_frz;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Hold keys long enough to debounce, release, and let the FSM settle to IDLE.
    task automatic press(input logic [3:0] mask, output logic [3:0] seen, output int npulse);
        key    = mask;
        seen   = '0;
        npulse = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (new_press != 0) begin
                seen |= new_press;
                npulse++;
            end
        end
        key = '0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (new_press != 0) npulse++;
        end
    endtask

    task automatic commit(input int em, input logic ef, input string tag);
        fs = 1'b1;
        tick();
        fs = 1'b0;
        check({tag, "_mode"}, mode, em);
        check({tag, "_frz"}, freeze, ef);
        tick();
        check({tag, "_pend_after"}, pending, 0);
    endtask

    task automatic wait_pulse(input logic [3:0] mask, output logic ok, output logic [3:0] seen);
        key  = mask;
        ok   = 1'b0;
        seen = '0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (new_press != 0) begin
                ok   = 1'b1;
                seen = new_press;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] seen;
        int         np;
        int         first;
        logic       ok;

        vecs[0]  = '{4'b1000, 4'b1000, 0, 1'b0};
        vecs[1]  = '{4'b0010, 4'b0010, 7, 1'b0};
        vecs[2]  = '{4'b0001, 4'b0001, 0, 1'b0};
        vecs[3]  = '{4'b0001, 4'b0001, 1, 1'b0};
        vecs[4]  = '{4'b0100, 4'b0100, 1, 1'b1};
        vecs[5]  = '{4'b0100, 4'b0100, 1, 1'b0};
        vecs[6]  = '{4'b0011, 4'b0011, 0, 1'b0};
        vecs[7]  = '{4'b0010, 4'b0010, 7, 1'b0};
        vecs[8]  = '{4'b0010, 4'b0010, 6, 1'b0};
        vecs[9]  = '{4'b0010, 4'b0010, 5, 1'b0};
        vecs[10] = '{4'b1001, 4'b1001, 0, 1'b0};
        vecs[11] = '{4'b0110, 4'b0110, 0, 1'b1};
        vecs[12] = '{4'b1100, 4'b1100, 0, 1'b0};

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check("rst_press", new_press, 0);
        check("rst_mode", mode, 0);
        check("rst_frz", freeze, 0);
        check("rst_pend", pending, 0);
        rst = 1'b0;
        tick();

        // Glitch of 3 cycles must be rejected
        np  = 0;
        key = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (new_press != 0) np++;
        end
        key = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (new_press != 0) np++;
        end
        check("glitch_pulses", np, 0);
        check("glitch_pend", pending, 0);
        check("glitch_mode", mode, 0);

        // Clean press: pulse 7 cycles after the raw edge, exactly once
        np    = 0;
        first = -1;
        key   = 4'b0001;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (new_press[0]) begin
                np++;
                if (first < 0) first = i;
            end
            if (i == 10) key = '0;
        end
        for (int i = 0; i < 14; i++) begin
            tick();
            if (new_press != 0) np++;
        end
        check("t1_latency", first, 7);
        check("t1_pulses", np, 1);
        check("t1_pend_pre", pending, 1);
        commit(1, 1'b0, "t1");
        cur_mode = 1;
        cur_frz  = 1'b0;

        // Table of single/simultaneous presses, each committed at a frame start
        for (int v = 0; v < 13; v++) begin
            press(vecs[v].keys, seen, np);
            check($sformatf("vec%0d_bits", v), seen, vecs[v].exp_press);
            check($sformatf("vec%0d_npulse", v), np, 1);
            check($sformatf("vec%0d_pend_pre", v), pending,
                  ((vecs[v].exp_mode != cur_mode) || (vecs[v].exp_frz != cur_frz)) ? 1 : 0);
            commit(vecs[v].exp_mode, vecs[v].exp_frz, $sformatf("vec%0d", v));
            cur_mode = vecs[v].exp_mode;
            cur_frz  = vecs[v].exp_frz;
        end

        // Auto-repeat: press step, hold expiry step, two repeat steps
        wait_pulse(4'b0001, ok, seen);
        check("t4_pulse_seen", ok, 1);
        repeat (21) tick();
        key = '0;
        repeat (30) tick();
        check("t4_pend_pre", pending, 1);
        commit(4, 1'b0, "t4");
        repeat (40) tick();
        check("t4_no_more_steps", pending, 0);
        check("t4_mode_stable", mode, 4);

        // Commit uses the staged value from before a same-cycle press
        press(4'b0010, seen, np);
        press(4'b0010, seen, np);
        check("t5_pend_pre", pending, 1);
        check("t5_mode_pre", mode, 4);
        wait_pulse(4'b0001, ok, seen);
        check("t5_pulse_seen", ok, 1);
        fs = 1'b1;
        tick();
        fs = 1'b0;
        check("t5_mode_now", mode, 2);
        key = '0;
        repeat (20) tick();
        commit(3, 1'b0, "t5_next");

        // Reset during REPEAT, key held through reset release
        press(4'b0100, seen, np);
        press(4'b0001, seen, np);
        press(4'b0001, seen, np);
        press(4'b0001, seen, np);
        commit(6, 1'b1, "t6_pre");
        wait_pulse(4'b0001, ok, seen);
        check("t6_pulse_seen", ok, 1);
        repeat (20) tick();
        rst = 1'b1;
        tick();
        check("t6_rst_press", new_press, 0);
        check("t6_rst_mode", mode, 0);
        check("t6_rst_frz", freeze, 0);
        check("t6_rst_pend", pending, 0);
        rst   = 1'b0;
        np    = 0;
        first = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (new_press[0]) begin
                np++;
                if (first < 0) first = i;
            end
        end
        key = '0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (new_press != 0) np++;
        end
        check("t6_latency", first, 7);
        check("t6_pulses", np, 1);
        commit(1, 1'b0, "t6_post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
